// File: rtl/oldland_bus_arbiter_pkg.sv
// Package: oldland_bus_arbiter_pkg
// Shared definitions for the oldland memory bus arbiter:
//   - FSM state encodings for the arbiter controller
//   - clog2_min1(): $clog2 clamped to at least 1 bit, so counters and
//     pointers stay legal vectors for degenerate parameter values
//     (one master, timeout disabled).

package oldland_bus_arbiter_pkg;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StBusy    = 2'd1;
   localparam logic [1:0] StRelease = 2'd2;

   function automatic int unsigned clog2_min1(input int unsigned value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/oldland_rr_picker.sv
// Module: oldland_rr_picker
// Combinational one-hot request picker.
//   req   in  N      request vector
//   base  in  BaseW  index of the last master served
//   rr_en in  1      1 = search from base+1 (mod N); 0 = lowest index wins
//   gnt   out N      one-hot winner, all zero when nothing requests

module oldland_rr_picker
   import oldland_bus_arbiter_pkg::*;
#(
   parameter int unsigned N     = 2,
   parameter int unsigned BaseW = clog2_min1(N)
) (
   input  logic [N-1:0]     req,
   input  logic [BaseW-1:0] base,
   input  logic             rr_en,
   output logic [N-1:0]     gnt
);

   logic        found;
   int unsigned pos;

   // Walk the candidates in search order; the first requester wins.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      pos   = 0;
      for (int unsigned o = 0; o < N; o++) begin
         pos = rr_en ? ((32'(base) + 32'd1 + o) % N) : o;
         for (int unsigned j = 0; j < N; j++) begin
            if (!found && (j == pos) && req[j]) begin
               gnt[j] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/oldland_bus_arbiter.sv
// Module: oldland_bus_arbiter
// N-master to 1-slave arbiter for the oldland memory bus (access/ack/error
// handshake), with fixed or round-robin arbitration and a per-transaction
// timeout that answers a stuck access with a bus error.
//   clk, rst_n          clock, asynchronous active-low reset
//   m_access/m_addr/m_bytesel/m_wr_en/m_wr_val   packed per-master requests
//   m_data              shared read data, valid with m_ack
//   m_ack, m_error      one-cycle completion / error pulses to the owner
//   s_access/s_addr/s_bytesel/s_wr_en/s_wr_val   muxed slave request
//   s_data, s_ack, s_error                       slave response
//   grant               one-hot current owner, 0 when idle

module oldland_bus_arbiter
   import oldland_bus_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS    = 2,
   parameter int unsigned ADDR_W         = 30,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned RR_MODE        = 1,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_MASTERS-1:0]          m_access,
   input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [NUM_MASTERS*DATA_W/8-1:0] m_bytesel,
   input  logic [NUM_MASTERS-1:0]          m_wr_en,
   input  logic [NUM_MASTERS*DATA_W-1:0]   m_wr_val,
   output logic [DATA_W-1:0]               m_data,
   output logic [NUM_MASTERS-1:0]          m_ack,
   output logic [NUM_MASTERS-1:0]          m_error,
   output logic                            s_access,
   output logic [ADDR_W-1:0]               s_addr,
   output logic [DATA_W/8-1:0]             s_bytesel,
   output logic                            s_wr_en,
   output logic [DATA_W-1:0]               s_wr_val,
   input  logic [DATA_W-1:0]               s_data,
   input  logic                            s_ack,
   input  logic                            s_error,
   output logic [NUM_MASTERS-1:0]          grant
);

   localparam int unsigned BselW = DATA_W / 8;
   localparam int unsigned PtrW  = clog2_min1(NUM_MASTERS);
   localparam int unsigned CntW  = clog2_min1(TIMEOUT_CYCLES + 1);

   logic [1:0]             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [NUM_MASTERS-1:0] pick;
   logic [PtrW-1:0]        ptr_q, ptr_d;
   logic [PtrW-1:0]        grant_idx;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   busy, resp, timed_out, done;

   oldland_rr_picker #(
      .N     (NUM_MASTERS),
      .BaseW (PtrW)
   ) u_picker (
      .req   (m_access),
      .base  (ptr_q),
      .rr_en (RR_MODE != 0),
      .gnt   (pick)
   );

   always_comb begin
      grant_idx = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) grant_idx = PtrW'(i);
      end
   end

   assign busy = (state_q == StBusy);
   assign resp = busy && (s_ack || s_error);
   // A real response in the last allowed cycle beats the timeout.
   assign timed_out = busy && (TIMEOUT_CYCLES != 0) && !s_ack && !s_error &&
                      (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   assign done = resp || timed_out;

   // Responses outside BUSY are late answers to a timed-out access: ignored.
   assign s_access = busy;
   assign grant    = grant_q;
   assign m_ack    = (busy && s_ack && !s_error) ? grant_q : '0;
   assign m_error  = ((busy && s_error) || timed_out) ? grant_q : '0;

   // Read data passes straight through on the ack cycle; the register only
   // holds the last value for the cycles in between.
   assign data_d = (busy && s_ack) ? s_data : data_q;
   assign m_data = data_d;

   // AND-OR field mux; grant_q is one-hot or zero, so idle fields read as 0.
   always_comb begin
      s_addr    = '0;
      s_bytesel = '0;
      s_wr_en   = 1'b0;
      s_wr_val  = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) begin
            s_addr    = s_addr | m_addr[i*ADDR_W +: ADDR_W];
            s_bytesel = s_bytesel | m_bytesel[i*BselW +: BselW];
            s_wr_en   = s_wr_en | m_wr_en[i];
            s_wr_val  = s_wr_val | m_wr_val[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         // RELEASE already shows s_access=0/grant=0 for one cycle, so it may
         // arbitrate the next request itself: back-to-back costs one bubble.
         StIdle, StRelease: begin
            grant_d = '0;
            cnt_d   = '0;
            state_d = StIdle;
            if (|m_access) begin
               grant_d = pick;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (done) begin
               state_d = StRelease;
               grant_d = '0;
               ptr_d   = grant_idx;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         ptr_q   <= PtrW'(NUM_MASTERS - 1);
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

endmodule
